// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline encodings for the hazard controller: forward selects,
// the load result-select code and the memory-wait FSM states.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam int NUM_FWD = 2;  // ALU operands A and B
  localparam int REG_W   = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/forward_unit.sv
// Single-operand forwarding comparator; memory stage beats writeback and
// x0 is never forwarded.
module forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [1:0]       fwd_sel
);

  // Priority select: youngest producer wins
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e))
      fwd_sel = FWD_M;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e))
      fwd_sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: operand forwarding, load-use interlock,
// redirect flushes, memory-wait freeze and saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             regWrite_M,
  input  logic             regWrite_W,
  input  logic [1:0]       resultSrc_E,
  input  logic             pcSrc_E,
  input  logic             mem_req_M,
  input  logic             mem_ready,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  hz_state_t                        state_q, state_d;
  logic      [WAIT_W-1:0]           wait_cnt, wait_nxt;
  logic                             frz, frz_g, lu, lu_act, redirect, stall_any;
  logic      [NUM_FWD-1:0][REG_W-1:0] rs_e;
  logic      [NUM_FWD-1:0][1:0]       fwd;

  // Operand A is lane 0, operand B is lane 1
  assign rs_e = {Rs2_E, Rs1_E};

  for (genvar l = 0; l < NUM_FWD; l++) begin : g_fwd
    forward_unit u_fwd (
      .rs_e        (rs_e[l]),
      .rd_m        (Rd_M),
      .rd_w        (Rd_W),
      .reg_write_m (regWrite_M),
      .reg_write_w (regWrite_W),
      .fwd_sel     (fwd[l])
    );
  end

  // Every control output is forced idle while reset is held
  assign forwardA_E = rst ? FWD_RF : fwd[0];
  assign forwardB_E = rst ? FWD_RF : fwd[1];

  // Next state and the freeze condition; the release cycle does not freeze
  always_comb begin
    state_d = state_q;
    frz     = 1'b0;
    case (state_q)
      RUN: begin
        frz = mem_req_M && !mem_ready;
        if (mem_req_M && !mem_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        frz = !mem_ready;
        if (mem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Freeze overrides everything; a redirect overrides a load-use interlock,
  // so a redirect held during a freeze fires on the release cycle
  assign lu       = (resultSrc_E == RESULT_LOAD) && (Rd_E != '0) &&
                    ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
  assign frz_g    = frz && !rst;
  assign redirect = pcSrc_E && !frz && !rst;
  assign lu_act   = lu && !pcSrc_E && !frz && !rst;

  assign stall_F   = frz_g | lu_act;
  assign stall_D   = frz_g | lu_act;
  assign stall_E   = frz_g;
  assign stall_M   = frz_g;
  assign flush_D   = redirect;
  assign flush_E   = redirect | lu_act;
  assign flush_W   = frz_g;
  assign stall_any = stall_F | stall_D | stall_E | stall_M;

  assign wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Wait counter and sticky timeout; the freeze itself ignores the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state_q == RUN && state_d == MEM_WAIT) begin
      wait_cnt <= '0;
    end else if (state_q == MEM_WAIT && !mem_ready) begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_MAX) mem_timeout <= 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_any && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect  && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with narrow counters and a short timeout.
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic       regWrite_M, regWrite_W, pcSrc_E, mem_req_M, mem_ready;
  logic [1:0] resultSrc_E, forwardA_E, forwardB_E;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
  logic       mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.CNT_W(4), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E),
    .Rs2_E(Rs2_E), .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
    .regWrite_M(regWrite_M), .regWrite_W(regWrite_W), .resultSrc_E(resultSrc_E),
    .pcSrc_E(pcSrc_E), .mem_req_M(mem_req_M), .mem_ready(mem_ready),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E), .stall_F(stall_F),
    .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M), .flush_D(flush_D),
    .flush_E(flush_E), .flush_W(flush_W), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
  assign ctl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
    regWrite_M = 0; regWrite_W = 0; resultSrc_E = 2'b00; pcSrc_E = 0;
    mem_req_M = 0; mem_ready = 0;
  endtask

  task automatic set_lu;
    resultSrc_E = 2'b01; Rd_E = 7; Rs2_D = 7;
  endtask

  task automatic test_reset;
    rst = 1; idle();
    tick(); tick();
    set_lu(); pcSrc_E = 1; mem_req_M = 1; mem_ready = 0;
    Rs1_E = 5; Rd_M = 5; regWrite_M = 1; Rs2_E = 6; Rd_W = 6; regWrite_W = 1;
    #1;
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL rst_ctl: got %b want %b", ctl, 7'b0); end
    vectors++; if ({forwardA_E, forwardB_E} !== 4'b0) begin miscompares++; $display("FAIL rst_fwd: got %b want 0000", {forwardA_E, forwardB_E}); end
    tick();
    rst = 0; idle(); #1;
    vectors++; if ({mem_timeout, stall_cnt, flush_cnt} !== 9'b0) begin miscompares++; $display("FAIL rst_regs: got %b want 0", {mem_timeout, stall_cnt, flush_cnt}); end
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL rst_release_ctl: got %b want 0", ctl); end
  endtask

  task automatic test_forward;
    idle();
    Rs1_E = 5; Rd_M = 5; regWrite_M = 1; Rd_W = 5; regWrite_W = 1; #1;
    vectors++; if (forwardA_E !== 2'b10) begin miscompares++; $display("FAIL fwd_m_prio: got %b want 10", forwardA_E); end
    vectors++; if (forwardB_E !== 2'b00) begin miscompares++; $display("FAIL fwd_b_none: got %b want 00", forwardB_E); end
    regWrite_M = 0; #1;
    vectors++; if (forwardA_E !== 2'b01) begin miscompares++; $display("FAIL fwd_w: got %b want 01", forwardA_E); end
    Rs1_E = 0; Rd_M = 0; Rd_W = 0; regWrite_M = 1; regWrite_W = 1; #1;
    vectors++; if (forwardA_E !== 2'b00) begin miscompares++; $display("FAIL fwd_x0: got %b want 00", forwardA_E); end
    Rs1_E = 3; Rs2_E = 9; Rd_M = 9; Rd_W = 3; #1;
    vectors++; if ({forwardA_E, forwardB_E} !== 4'b0110) begin miscompares++; $display("FAIL fwd_ab: got %b want 0110", {forwardA_E, forwardB_E}); end
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL fwd_noctl: got %b want 0", ctl); end
  endtask

  task automatic test_load_use;
    idle(); set_lu(); #1;
    vectors++; if (ctl !== 7'b1100010) begin miscompares++; $display("FAIL lu_ctl: got %b want 1100010", ctl); end
    tick();
    vectors++; if (stall_cnt !== 4'd1) begin miscompares++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    idle(); #1;
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL lu_after: got %b want 0", ctl); end
    resultSrc_E = 2'b01; Rd_E = 0; Rs1_D = 0; #1;
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL lu_x0: got %b want 0", ctl); end
    resultSrc_E = 2'b00; Rd_E = 4; Rs1_D = 4; #1;
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL lu_alu: got %b want 0", ctl); end
  endtask

  task automatic test_redirect;
    idle(); set_lu(); pcSrc_E = 1; #1;
    vectors++; if (ctl !== 7'b0000110) begin miscompares++; $display("FAIL redir_ctl: got %b want 0000110", ctl); end
    tick();
    vectors++; if ({stall_cnt, flush_cnt} !== {4'd1, 4'd1}) begin miscompares++; $display("FAIL redir_cnt: got %0d/%0d want 1/1", stall_cnt, flush_cnt); end
    idle();
  endtask

  task automatic test_mem_wait;
    idle(); mem_req_M = 1; mem_ready = 0; pcSrc_E = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (ctl !== 7'b1111001) begin miscompares++; $display("FAIL mw_frz%0d: got %b want 1111001", i, ctl); end
      tick();
    end
    mem_ready = 1; #1;
    vectors++; if (ctl !== 7'b0000110) begin miscompares++; $display("FAIL mw_release: got %b want 0000110", ctl); end
    tick();
    vectors++; if ({stall_cnt, flush_cnt} !== {4'd5, 4'd2}) begin miscompares++; $display("FAIL mw_cnt: got %0d/%0d want 5/2", stall_cnt, flush_cnt); end
    idle(); #1;
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL mw_run: got %b want 0", ctl); end
  endtask

  task automatic test_timeout;
    idle(); rst = 1; tick();
    vectors++; if ({mem_timeout, stall_cnt, flush_cnt} !== 9'b0) begin miscompares++; $display("FAIL to_pre_rst: got %b want 0", {mem_timeout, stall_cnt, flush_cnt}); end
    rst = 0; mem_req_M = 1; mem_ready = 0;
    tick();
    mem_req_M = 0;
    tick();
    vectors++; if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL to_w1: got %b want 0", mem_timeout); end
    tick();
    vectors++; if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL to_w2: got %b want 0", mem_timeout); end
    tick();
    vectors++; if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL to_w3: got %b want 1", mem_timeout); end
    vectors++; if (ctl !== 7'b1111001) begin miscompares++; $display("FAIL to_frz_persist: got %b want 1111001", ctl); end
    tick(); tick();
    mem_ready = 1; #1;
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL to_release: got %b want 0", ctl); end
    tick();
    vectors++; if ({mem_timeout, stall_cnt} !== {1'b1, 4'd6}) begin miscompares++; $display("FAIL to_sticky: got %b/%0d want 1/6", mem_timeout, stall_cnt); end
    mem_ready = 0; rst = 1; tick();
    rst = 0; #1;
    vectors++; if ({mem_timeout, stall_cnt, flush_cnt} !== 9'b0) begin miscompares++; $display("FAIL to_rst_clear: got %b want 0", {mem_timeout, stall_cnt, flush_cnt}); end
  endtask

  task automatic test_reset_mid_wait;
    idle(); mem_req_M = 1; mem_ready = 0;
    tick(); tick();
    rst = 1; #1;
    vectors++; if ({ctl, forwardA_E, forwardB_E} !== 11'b0) begin miscompares++; $display("FAIL rmw_during: got %b want 0", {ctl, forwardA_E, forwardB_E}); end
    tick();
    rst = 0; mem_req_M = 0; #1;
    vectors++; if (ctl !== 7'b0) begin miscompares++; $display("FAIL rmw_run: got %b want 0", ctl); end
    vectors++; if ({mem_timeout, stall_cnt} !== 5'b0) begin miscompares++; $display("FAIL rmw_regs: got %b want 0", {mem_timeout, stall_cnt}); end
  endtask

  task automatic test_saturate;
    idle(); set_lu();
    repeat (14) tick();
    vectors++; if (stall_cnt !== 4'd14) begin miscompares++; $display("FAIL sat_14: got %0d want 14", stall_cnt); end
    repeat (6) tick();
    vectors++; if (stall_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_stall: got %0d want 15", stall_cnt); end
    pcSrc_E = 1;
    repeat (20) tick();
    vectors++; if ({stall_cnt, flush_cnt} !== {4'd15, 4'd15}) begin miscompares++; $display("FAIL sat_flush: got %0d/%0d want 15/15", stall_cnt, flush_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
